// File: rtl/ysyx_22050133_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22050133_mem_arbiter
//
// Shares the core's single memory port between the instruction fetch unit
// (IFU, port 0) and the load/store unit (LSU, port 1). One request is accepted
// at a time. It is latched and driven to memory with a valid/ready handshake.
// The memory response is then returned only to the port that was granted.
// This lets the stage sequencer work with multi-cycle memory.
//
// Transaction flow: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// WAIT is skipped when memory responds in the same cycle it accepts.
//
// Configuration macro:
//   ARB_RR_EN  When defined, simultaneous requests use round-robin arbitration.
//              A 1-bit last_grant register tracks the previous winner.
//              It resets to 0, which means IFU.
//              When undefined, arbitration is fixed priority and the LSU wins.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   if_req_valid/ready    IFU request handshake (ready is a 1-cycle accept pulse)
//   if_addr               IFU fetch address
//   if_resp_valid/rdata   IFU response pulse and read data
//   ls_req_valid/ready    LSU request handshake (ready is a 1-cycle accept pulse)
//   ls_addr, ls_wen,      LSU address, store enable, store data and byte mask
//   ls_wdata, ls_wmask
//   ls_resp_valid/rdata   LSU response pulse and load data (0 for stores)
//   mem_req_valid/ready   request handshake towards memory
//   mem_addr, mem_wen,    latched request payload towards memory
//   mem_wdata, mem_wmask
//   mem_resp_valid/rdata  memory response
//   busy                  high whenever a transaction is in flight
// ----------------------------------------------------------------------------
module ysyx_22050133_mem_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    // IFU port
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_rdata,
    // LSU port
    input  logic                  ls_req_valid,
    output logic                  ls_req_ready,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic                  ls_wen,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_resp_valid,
    output logic [DATA_W-1:0]     ls_rdata,
    // Memory port
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,
    // Status
    output logic                  busy
);

    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Latched request; grant_q is 0 for the IFU and 1 for the LSU.
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata_q;

    logic pick_ls;   // arbitration winner is the LSU
    logic accept;    // a request is accepted this cycle
    logic capture;   // memory read data is captured this cycle

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef ARB_RR_EN
    logic last_grant_q;  // previous winner: 0 = IFU, 1 = LSU

    always_comb begin
        pick_ls = ls_req_valid;
        // Give the tie to the port that did not win last time.
        if (if_req_valid && ls_req_valid) begin
            pick_ls = ~last_grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else if (accept) begin
            last_grant_q <= pick_ls;
        end
    end
`else
    always_comb begin
        pick_ls = ls_req_valid;
    end
`endif

    // Gated by rst so that the ready pulses stay low while reset is held.
    assign accept = !rst && (state_q == StIdle) && (if_req_valid || ls_req_valid);

    // A response is only taken while the request is in flight.
    // Stray responses in IDLE or RESP are dropped.
    assign capture = ((state_q == StIssue) && mem_req_ready && mem_resp_valid) ||
                     ((state_q == StWait) && mem_resp_valid);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem_req_ready) begin
                    state_d = mem_resp_valid ? StResp : StWait;
                end
            end
            StWait: begin
                if (mem_resp_valid) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        if_req_ready  = accept && !pick_ls;
        ls_req_ready  = accept && pick_ls;
        mem_req_valid = (state_q == StIssue);
        if_resp_valid = (state_q == StResp) && !grant_q;
        ls_resp_valid = (state_q == StResp) && grant_q;
        if_rdata      = '0;
        ls_rdata      = '0;
        if (if_resp_valid) begin
            if_rdata = rdata_q;
        end
        // Stores are acknowledged with zero data.
        if (ls_resp_valid && !wen_q) begin
            ls_rdata = rdata_q;
        end
        busy = (state_q != StIdle);
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    // ------------------------------------------------------------------------
    // Request latch and response data register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                grant_q <= pick_ls;
                if (pick_ls) begin
                    addr_q  <= ls_addr;
                    wen_q   <= ls_wen;
                    wdata_q <= ls_wdata;
                    wmask_q <= ls_wmask;
                end else begin
                    // Fetches never write memory.
                    addr_q  <= if_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_mem_arbiter.sv
// ----------------------------------------------------------------------------
// Self-checking testbench for ysyx_22050133_mem_arbiter.
// Both requesters and the memory are driven from the bench. Expected
// behaviour is computed at transaction level: which port wins, what payload
// reaches memory, and which port gets which data back.
// Inputs change 1 time unit after posedge. Outputs are sampled 1 unit later.
// ----------------------------------------------------------------------------
module tb_ysyx_22050133_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_resp_valid;
    logic [63:0] ls_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit hold   = 1'b0;  // the winner keeps requesting after being accepted
`ifdef ARB_RR_EN
    bit model_last = 1'b0;  // previous winner in the reference model, 1 = LSU
`endif

    always #5 clk = ~clk;

    ysyx_22050133_mem_arbiter #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .ls_req_valid   (ls_req_valid),
        .ls_req_ready   (ls_req_ready),
        .ls_addr        (ls_addr),
        .ls_wen         (ls_wen),
        .ls_wdata       (ls_wdata),
        .ls_wmask       (ls_wmask),
        .ls_resp_valid  (ls_resp_valid),
        .ls_rdata       (ls_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid   = 1'b0;
        if_addr        = '0;
        ls_req_valid   = 1'b0;
        ls_addr        = '0;
        ls_wen         = 1'b0;
        ls_wdata       = '0;
        ls_wmask       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
`ifdef ARB_RR_EN
        model_last = 1'b0;
`endif
    endtask

    // Run one transaction. Call it at an IDLE cycle, after the request inputs
    // are driven. rd_dly is the number of cycles mem_req_ready is held low.
    // rs_dly is the number of cycles from the ready cycle to the response.
    // It returns at the next IDLE cycle.
    task automatic do_txn(input int rd_dly, input int rs_dly, input logic [63:0] rdat);
        logic        exp_ls;
        logic [63:0] e_addr;
        logic        e_wen;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic [63:0] e_if_rdata;
        logic [63:0] e_ls_rdata;
        #1;
        // Arbiter must be idle with no response pending.
        checks++;
        if (busy !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: busy=%b if_resp=%b ls_resp=%b, required 0 0 0",
                     busy, if_resp_valid, ls_resp_valid);
        end
        exp_ls = ls_req_valid;
`ifdef ARB_RR_EN
        if (if_req_valid && ls_req_valid) exp_ls = !model_last;
        model_last = exp_ls;
`endif
        checks++;
        if (if_req_ready !== (!exp_ls) || ls_req_ready !== exp_ls) begin
            errors++;
            $display("FAIL accept: if_ready=%b ls_ready=%b, required %b %b",
                     if_req_ready, ls_req_ready, !exp_ls, exp_ls);
        end
        if (exp_ls) begin
            e_addr = ls_addr; e_wen = ls_wen; e_wdata = ls_wdata; e_wmask = ls_wmask;
        end else begin
            e_addr = if_addr; e_wen = 1'b0; e_wdata = '0; e_wmask = '0;
        end
        e_if_rdata = exp_ls ? 64'd0 : rdat;
        e_ls_rdata = (exp_ls && !e_wen) ? rdat : 64'd0;
        tick();
        // Drop the winner and change its payload so any late sampling shows.
        if (!hold) begin
            if (exp_ls) begin
                ls_req_valid = 1'b0;
                ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom};
                ls_wmask = 8'($urandom); ls_wen = ~ls_wen;
            end else begin
                if_req_valid = 1'b0;
                if_addr = {$urandom, $urandom};
            end
        end
        // Issue phase
        for (int i = 0; i <= rd_dly; i++) begin
            mem_req_ready  = (i == rd_dly);
            mem_resp_valid = (i == rd_dly) && (rs_dly == 0);
            mem_rdata      = mem_resp_valid ? rdat : {$urandom, $urandom};
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== e_addr || mem_wen !== e_wen ||
                mem_wdata !== e_wdata || mem_wmask !== e_wmask) begin
                errors++;
                $display("FAIL issue_payload: valid=%b addr=%h wen=%b wdata=%h wmask=%h, required 1 %h %b %h %h",
                         mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                         e_addr, e_wen, e_wdata, e_wmask);
            end
            checks++;
            if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 ||
                if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL issue_quiet: if_rdy=%b ls_rdy=%b if_resp=%b ls_resp=%b busy=%b, required 0 0 0 0 1",
                         if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, busy);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        // Wait phase
        for (int j = 1; j <= rs_dly; j++) begin
            mem_resp_valid = (j == rs_dly);
            mem_rdata      = mem_resp_valid ? rdat : {$urandom, $urandom};
            #1;
            checks++;
            if (mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 ||
                if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL wait_quiet: mem_valid=%b if_resp=%b ls_resp=%b if_rdy=%b ls_rdy=%b, required all 0",
                         mem_req_valid, if_resp_valid, ls_resp_valid, if_req_ready, ls_req_ready);
            end
            tick();
        end
        // Response cycle. Memory signals carry unrelated data that must be ignored.
        mem_resp_valid = 1'b0;
        mem_rdata      = {$urandom, $urandom};
        #1;
        checks++;
        if (if_resp_valid !== (!exp_ls) || ls_resp_valid !== exp_ls ||
            if_rdata !== e_if_rdata || ls_rdata !== e_ls_rdata) begin
            errors++;
            $display("FAIL response: if_resp=%b if_rdata=%h ls_resp=%b ls_rdata=%h, required %b %h %b %h",
                     if_resp_valid, if_rdata, ls_resp_valid, ls_rdata,
                     !exp_ls, e_if_rdata, exp_ls, e_ls_rdata);
        end
        checks++;
        if (if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_quiet: if_rdy=%b ls_rdy=%b mem_valid=%b, required 0 0 0",
                     if_req_ready, ls_req_ready, mem_req_valid);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || if_req_ready !== 1'b0 ||
            ls_req_ready !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b mem_valid=%b if_rdy=%b ls_rdy=%b if_resp=%b ls_resp=%b, required all 0",
                     busy, mem_req_valid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid);
        end
        checks++;
        if (mem_addr !== 64'd0 || mem_wen !== 1'b0 || mem_wdata !== 64'd0 ||
            mem_wmask !== 8'd0 || if_rdata !== 64'd0 || ls_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wen=%b wdata=%h wmask=%h if_rdata=%h ls_rdata=%h, required all 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask, if_rdata, ls_rdata);
        end
        rst = 1'b0;
        clear_inputs();
`ifdef ARB_RR_EN
        model_last = 1'b0;
`endif
        tick();
    endtask

    task automatic test_ifu_read();
        hold = 1'b0;
        if_req_valid = 1'b1;
        if_addr = 64'h8000_0000;
        do_txn(0, 0, 64'h0000_0413);
    endtask

    task automatic test_lsu_store();
        hold = 1'b0;
        ls_req_valid = 1'b1;
        ls_addr  = 64'h8000_1008;
        ls_wen   = 1'b1;
        ls_wdata = 64'hDEAD_BEEF;
        ls_wmask = 8'h0F;
        do_txn(3, 2, 64'h1234_5678_9abc_def0);
    endtask

    task automatic test_both_valid();
        // Winner drops valid after acceptance.
        apply_reset();
        hold = 1'b0;
        if_req_valid = 1'b1; if_addr = 64'h8000_0100;
        ls_req_valid = 1'b1; ls_addr = 64'h8000_2000; ls_wen = 1'b0;
        ls_wdata = 64'h0; ls_wmask = 8'h0;
        do_txn(0, 0, 64'hAAAA_0001);
        do_txn(0, 0, 64'hAAAA_0002);
        // Both keep requesting for three grants.
        apply_reset();
        hold = 1'b1;
        if_req_valid = 1'b1; if_addr = 64'h8000_0200;
        ls_req_valid = 1'b1; ls_addr = 64'h8000_3000; ls_wen = 1'b0;
        do_txn(0, 0, 64'hBBBB_0001);
        do_txn(0, 0, 64'hBBBB_0002);
        do_txn(0, 0, 64'hBBBB_0003);
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        hold = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        hold = 1'b0;
        if_req_valid = 1'b1;
        if_addr = 64'h8000_0400;
        tick();                       // accepted; now issuing
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();                       // accepted by memory; now waiting
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: busy=%b mem_valid=%b, required 1 0", busy, mem_req_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef ARB_RR_EN
        model_last = 1'b0;
`endif
        mem_resp_valid = 1'b1;
        mem_rdata = 64'hBAD0_BAD0;
        #1;
        checks++;
        if (busy !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b if_resp=%b ls_resp=%b, required 0 0 0",
                     busy, if_resp_valid, ls_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 ||
            if_rdata !== 64'd0 || ls_rdata !== 64'd0) begin
            errors++;
            $display("FAIL late_resp: busy=%b if_resp=%b ls_resp=%b if_rdata=%h ls_rdata=%h, required 0 0 0 0 0",
                     busy, if_resp_valid, ls_resp_valid, if_rdata, ls_rdata);
        end
        tick();
    endtask

    task automatic test_stray_resp();
        mem_resp_valid = 1'b1;
        mem_rdata = 64'h5555_AAAA_5555_AAAA;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0 ||
            ls_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_now: busy=%b mem_valid=%b if_resp=%b ls_resp=%b, required 0 0 0 0",
                     busy, mem_req_valid, if_resp_valid, ls_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_after: busy=%b if_resp=%b ls_resp=%b, required 0 0 0",
                     busy, if_resp_valid, ls_resp_valid);
        end
        tick();
        if_req_valid = 1'b1;
        if_addr = 64'h8000_0800;
        do_txn(1, 1, 64'h0000_0013);
    endtask

    task automatic test_random();
        hold = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (!if_req_valid && ($urandom_range(1, 0) == 1)) begin
                if_req_valid = 1'b1;
                if_addr = {32'h0, $urandom} & 64'hFFFF_FFFC;
            end
            if (!ls_req_valid && (($urandom_range(1, 0) == 1) || !if_req_valid)) begin
                ls_req_valid = 1'b1;
                ls_addr  = {32'h0, $urandom};
                ls_wen   = 1'($urandom);
                ls_wdata = {$urandom, $urandom};
                ls_wmask = 8'($urandom);
            end
            do_txn(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   {$urandom, $urandom});
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_both_valid();
        test_reset_mid();
        test_stray_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
